sample_window_buffer: RTL and testbench

- Circular sample store that sits on the memory side of the pitch-detection difference stage: receives the incoming audio sample stream and answers that stage's address/data reads.
- Tells the consumer when a full analysis frame (window + max lag) is resident and where it starts; the consumer releases it with frame_done, which advances the frame by one hop.
- Holds unconsumed samples so they are never overwritten.

---
 rtl/sample_window_buffer.sv | 96 +++++++++
 tb/tb_sample_window_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sample_window_buffer.sv
// Circular sample store for the pitch-detection difference stage: buffers the
// incoming stream, serves registered reads and flags when a full analysis frame is resident.
module sample_window_buffer #(
  parameter int DATA_WIDTH       = 16,
  parameter int WINDOW_SIZE_BITS = 8,
  parameter int MAX_TAU          = 40,
  parameter int DEPTH_BITS       = 9,
  parameter int HOP              = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_sample,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           rd_address,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  frame_ready,
  output logic [15:0]           frame_base,
  input  logic                  frame_done,
  output logic [DEPTH_BITS:0]   fill_count,
  output logic                  overflow
);

  localparam int DEPTH     = 1 << DEPTH_BITS;
  localparam int FRAME_LEN = (1 << WINDOW_SIZE_BITS) + MAX_TAU;
  localparam logic [DEPTH_BITS:0]   FRAME_W = (DEPTH_BITS+1)'(FRAME_LEN);
  localparam logic [DEPTH_BITS:0]   HOP_W   = (DEPTH_BITS+1)'(HOP);
  localparam logic [DEPTH_BITS-1:0] HOP_P   = DEPTH_BITS'(HOP);

  // FILL  : accumulating, no frame offered
  // FRAME : frame_ready held, frame_base stable until frame_done
  typedef enum logic {FILL, FRAME} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_BITS-1:0]   wr_ptr;
  logic [DEPTH_BITS-1:0]   base_ptr;
  logic                    wr_en;
  logic                    done_acc;
  logic [DEPTH_BITS:0]     fill_next;
  logic                    unused_addr;

  // fill_count never exceeds DEPTH, so its MSB alone marks "full".
  assign in_ready    = ~fill_count[DEPTH_BITS];
  assign wr_en       = in_valid & in_ready;
  assign done_acc    = frame_done & (state == FRAME);
  assign frame_base  = 16'(base_ptr);
  assign unused_addr = ^rd_address[15:DEPTH_BITS];

  always_comb begin
    fill_next = fill_count + (DEPTH_BITS+1)'(wr_en);
    if (done_acc) fill_next = fill_next - HOP_W;
  end

  // Memory is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_sample;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      frame_ready <= 1'b0;
      wr_ptr      <= '0;
      base_ptr    <= '0;
      fill_count  <= '0;
      overflow    <= 1'b0;
      rd_data     <= '0;
    end else begin
      rd_data    <= mem[rd_address[DEPTH_BITS-1:0]];
      fill_count <= fill_next;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (in_valid && !in_ready) overflow <= 1'b1;
      case (state)
        FILL: begin
          if (fill_next >= FRAME_W) begin
            state       <= FRAME;
            frame_ready <= 1'b1;
          end
        end
        FRAME: begin
          if (frame_done) begin
            base_ptr    <= base_ptr + HOP_P;
            state       <= FILL;
            frame_ready <= 1'b0;
          end
        end
        default: begin
          state       <= FILL;
          frame_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_window_buffer.sv
// Directed bench for sample_window_buffer: a spec-level model tracks fill/base/frame
// state, and a read scoreboard queues expected rd_data when each address is applied.
module tb_sample_window_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_sample;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] rd_address;
  logic [15:0] rd_data;
  logic        frame_ready;
  logic [15:0] frame_base;
  logic        frame_done;
  logic [9:0]  fill_count;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem_m [512];
  int          m_fill, m_base, m_wp;
  bit          m_ready, m_ovf;
  logic [15:0] exp_q [$];

  sample_window_buffer dut (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
    .in_ready(in_ready), .rd_address(rd_address), .rd_data(rd_data),
    .frame_ready(frame_ready), .frame_base(frame_base), .frame_done(frame_done),
    .fill_count(fill_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".fill"},     32'(fill_count),  32'(m_fill));
    check({tag, ".base"},     32'(frame_base),  32'(m_base));
    check({tag, ".ready"},    32'(frame_ready), 32'(m_ready));
    check({tag, ".ovf"},      32'(overflow),    32'(m_ovf));
    check({tag, ".in_ready"}, 32'(in_ready),    32'(m_fill < 512));
  endtask

  // One clock of stimulus; the model applies the specified update rules.
  task automatic step(input bit v, input int s, input bit d, input bit rd, input int addr,
                      input string tag);
    bit acc, wr;
    int nf;
    in_valid   = v;
    in_sample  = s[15:0];
    frame_done = d;
    rd_address = addr[15:0];
    if (rd) exp_q.push_back(mem_m[addr % 512]);
    acc = d && m_ready;
    wr  = v && (m_fill < 512);
    if (v && !wr) m_ovf = 1'b1;
    if (wr) begin
      mem_m[m_wp] = s[15:0];
      m_wp = (m_wp + 1) % 512;
    end
    nf = m_fill + int'(wr) - (acc ? 128 : 0);
    if (m_ready) begin
      if (acc) begin
        m_ready = 1'b0;
        m_base  = (m_base + 128) % 512;
      end
    end else if (nf >= 296) begin
      m_ready = 1'b1;
    end
    m_fill = nf;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    frame_done = 1'b0;
    check_state(tag);
    if (rd) begin
      if (exp_q.size() == 0) check({tag, ".q_empty"}, 32'd1, 32'd0);
      else check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_sample = 16'hABCD;
    repeat (2) begin @(posedge clk); #1; end
    reset    = 1'b0;
    in_valid = 1'b0;
    m_fill = 0; m_base = 0; m_wp = 0; m_ready = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  task automatic write_range(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) step(1'b1, i, 1'b0, 1'b0, 0, tag);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sample = '0; rd_address = '0; frame_done = 1'b0;

    // Reset with in_valid held high: nothing written.
    do_reset();
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.ready",    32'(frame_ready), 32'd0);
    check("rst.fill",     32'(fill_count), 32'd0);
    check("rst.ovf",      32'(overflow), 32'd0);
    check("rst.rd_data",  32'(rd_data), 32'd0);

    // First frame.
    write_range(0, 294, "fill");
    check("first.fill295",  32'(fill_count), 32'd295);
    check("first.ready295", 32'(frame_ready), 32'd0);
    step(1'b1, 295, 1'b0, 1'b0, 0, "w295");
    check("first.ready", 32'(frame_ready), 32'd1);
    check("first.base",  32'(frame_base), 32'd0);
    step(1'b0, 0, 1'b0, 1'b1, 5, "rd5");
    check("rd5.value", 32'(rd_data), 32'd5);
    step(1'b0, 0, 1'b0, 1'b1, 295, "rd295");
    check("rd295.value", 32'(rd_data), 32'd295);

    // Hop.
    step(1'b0, 0, 1'b1, 1'b0, 0, "hop1");
    check("hop1.base",  32'(frame_base), 32'd128);
    check("hop1.fill",  32'(fill_count), 32'd168);
    check("hop1.ready", 32'(frame_ready), 32'd0);
    write_range(296, 423, "refill");
    check("refill.ready", 32'(frame_ready), 32'd1);
    step(1'b0, 0, 1'b0, 1'b1, 128, "rd128");
    check("rd128.value", 32'(rd_data), 32'd128);

    // Write and frame_done together at fill_count=300.
    write_range(424, 427, "to300");
    check("to300.fill", 32'(fill_count), 32'd300);
    step(1'b1, 428, 1'b1, 1'b0, 0, "simul");
    check("simul.fill", 32'(fill_count), 32'd173);
    check("simul.base", 32'(frame_base), 32'd256);
    step(1'b0, 0, 1'b0, 1'b1, 428, "rd428");
    check("rd428.value", 32'(rd_data), 32'd428);

    // Full and overflow.
    do_reset();
    write_range(0, 511, "full");
    check("full.fill",     32'(fill_count), 32'd512);
    check("full.in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 512, 1'b0, 1'b0, 0, "drop");
    check("drop.ovf",  32'(overflow), 32'd1);
    check("drop.fill", 32'(fill_count), 32'd512);
    step(1'b0, 0, 1'b1, 1'b0, 0, "full_done");
    check("full_done.in_ready", 32'(in_ready), 32'd1);
    check("full_done.ovf",      32'(overflow), 32'd1);
    check("full_done.ready",    32'(frame_ready), 32'd0);
    step(1'b0, 0, 1'b1, 1'b0, 0, "ignored_done");
    check("ignored.fill",  32'(fill_count), 32'd384);
    check("ignored.base",  32'(frame_base), 32'd128);
    check("ignored.ready", 32'(frame_ready), 32'd1);

    // Wrap: base walks 0,128,256,384,0.
    do_reset();
    write_range(0, 295, "wrap0");
    check("wrap.base0", 32'(frame_base), 32'd0);
    step(1'b0, 0, 1'b1, 1'b0, 0, "wrap_hop1");
    check("wrap.base1", 32'(frame_base), 32'd128);
    write_range(296, 423, "wrap1");
    step(1'b0, 0, 1'b1, 1'b0, 0, "wrap_hop2");
    check("wrap.base2", 32'(frame_base), 32'd256);
    write_range(424, 551, "wrap2");
    step(1'b0, 0, 1'b1, 1'b0, 0, "wrap_hop3");
    check("wrap.base3", 32'(frame_base), 32'd384);
    // Read the slot being written this cycle: old content comes back.
    step(1'b1, 552, 1'b0, 1'b1, 40, "rbw");
    check("rbw.value", 32'(rd_data), 32'd40);
    write_range(553, 679, "wrap3");
    check("wrap3.ready", 32'(frame_ready), 32'd1);
    step(1'b0, 0, 1'b0, 1'b1, 584, "rd584");
    check("rd584.value", 32'(rd_data), 32'd584);
    step(1'b0, 0, 1'b1, 1'b0, 0, "wrap_hop4");
    check("wrap.base4", 32'(frame_base), 32'd0);
    write_range(680, 807, "wrap4");
    check("wrap4.ready", 32'(frame_ready), 32'd1);

    // Reset mid-frame.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst.ready", 32'(frame_ready), 32'd0);
    check("midrst.fill",  32'(fill_count), 32'd0);
    check("midrst.base",  32'(frame_base), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
